// File: rtl/round_scheduler.sv
// round_scheduler
//   Sequences a multi-round baccarat session around the per-round dealing FSM.
//   Each round it pulses round_start, waits for round_done, tallies the win
//   lights, deducts the cards dealt from the shoe, and requests a reshuffle
//   whenever fewer than 6 cards remain before a round.
//
// Optional feature macro: ROUND_WATCHDOG_EN
//   Defined   : WAIT is guarded by a TIMEOUT-cycle watchdog that sets the sticky
//               timeout_err flag and ends the session.
//   Undefined : WAIT waits indefinitely; timeout_err is tied to 0.
//
// Handshakes: go is a level sampled only in IDLE; round_done is a one-cycle
// pulse honoured only in WAIT (its lights/cards_used are sampled with it);
// reshuffle_req is a level held until reshuffle_ack is seen in SHUFFLE.
//
// Ports
//   slow_clock                  sole clock, rising edge
//   resetb                      synchronous active-high reset
//   go, num_rounds              session start request / rounds to play
//   round_start                 one-cycle pulse to the dealing FSM
//   round_done, *_win_light,
//   cards_used                  end-of-round result from the dealing FSM
//   reshuffle_req/ack           shoe refill handshake
//   player_wins, dealer_wins,
//   ties                        saturating tallies
//   shoe_left                   cards remaining in shoe
//   busy, session_done          status
//   timeout_err                 sticky watchdog flag
//   dbg_state                   current FSM state encoding
module round_scheduler #(
  parameter int ROUNDS_W    = 4,
  parameter int COUNT_W     = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int SHOE_CARDS  = 52,
  parameter int TIMEOUT     = 64
) (
  input  logic                slow_clock,
  input  logic                resetb,
  input  logic                go,
  input  logic [ROUNDS_W-1:0] num_rounds,
  output logic                round_start,
  input  logic                round_done,
  input  logic                player_win_light,
  input  logic                dealer_win_light,
  input  logic [2:0]          cards_used,
  output logic                reshuffle_req,
  input  logic                reshuffle_ack,
  output logic [COUNT_W-1:0]  player_wins,
  output logic [COUNT_W-1:0]  dealer_wins,
  output logic [COUNT_W-1:0]  ties,
  output logic [5:0]          shoe_left,
  output logic                busy,
  output logic                session_done,
  output logic                timeout_err,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_SHUFFLE = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_HOLD    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // A hold of 0 cycles still spends one cycle in HOLD.
  localparam int         HOLD_MAX  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
  localparam logic [5:0]  SHOE_INIT = 6'(SHOE_CARDS);
  localparam logic [5:0]  SHOE_MIN  = 6'd6;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [2:0]          state_q, state_d;
  logic [ROUNDS_W-1:0] rounds_q, rounds_d;
  logic [COUNT_W-1:0]  pw_q, pw_d, dw_q, dw_d, tie_q, tie_d;
  logic [5:0]          shoe_q, shoe_d;
  logic [15:0]         hold_q, hold_d;
  logic                tmo_q, tmo_d;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

`ifdef ROUND_WATCHDOG_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    pw_d     = pw_q;
    dw_d     = dw_q;
    tie_d    = tie_q;
    shoe_d   = shoe_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
`ifdef ROUND_WATCHDOG_EN
    wd_d     = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) begin
          rounds_d = num_rounds;
          pw_d     = '0;
          dw_d     = '0;
          tie_d    = '0;
          tmo_d    = 1'b0;
          state_d  = (num_rounds == '0) ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: state_d = (shoe_q < SHOE_MIN) ? S_SHUFFLE : S_START;
      S_SHUFFLE: begin
        if (reshuffle_ack) begin
          shoe_d  = SHOE_INIT;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef ROUND_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        // round_done on the final watchdog cycle still completes the round.
        if (round_done) begin
          case ({player_win_light, dealer_win_light})
            2'b10:   pw_d  = sat_inc(pw_q);
            2'b01:   dw_d  = sat_inc(dw_q);
            2'b11:   tie_d = sat_inc(tie_q);
            default: ;
          endcase
          shoe_d   = ({3'b000, cards_used} > shoe_q) ? 6'd0
                                                     : shoe_q - {3'b000, cards_used};
          rounds_d = rounds_q - 1'b1;
          hold_d   = '0;
          state_d  = S_HOLD;
        end
`ifdef ROUND_WATCHDOG_EN
        else if (wd_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = (rounds_q == '0) ? S_DONE : S_CHECK;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: if (!go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_q  <= S_IDLE;
      rounds_q <= '0;
      pw_q     <= '0;
      dw_q     <= '0;
      tie_q    <= '0;
      shoe_q   <= SHOE_INIT;
      hold_q   <= '0;
      tmo_q    <= 1'b0;
`ifdef ROUND_WATCHDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rounds_q <= rounds_d;
      pw_q     <= pw_d;
      dw_q     <= dw_d;
      tie_q    <= tie_d;
      shoe_q   <= shoe_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
`ifdef ROUND_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign round_start   = (state_q == S_START);
  assign reshuffle_req = (state_q == S_SHUFFLE);
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign session_done  = (state_q == S_DONE);
  assign player_wins   = pw_q;
  assign dealer_wins   = dw_q;
  assign ties          = tie_q;
  assign shoe_left     = shoe_q;
`ifdef ROUND_WATCHDOG_EN
  assign timeout_err   = tmo_q;
`else
  assign timeout_err   = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_round_scheduler.sv
module tb_round_scheduler;

  logic       clk = 1'b0;
  logic       resetb;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main DUT (default widths)
  logic       go, round_done, pwl, dwl, ack;
  logic [3:0] num_rounds;
  logic [2:0] cards_used;
  logic       round_start, reshuffle_req, busy, session_done, timeout_err;
  logic [7:0] player_wins, dealer_wins, ties;
  logic [5:0] shoe_left;
  logic [2:0] dbg_state;

  round_scheduler #(.TIMEOUT(16)) dut (
    .slow_clock(clk), .resetb(resetb), .go(go), .num_rounds(num_rounds),
    .round_start(round_start), .round_done(round_done),
    .player_win_light(pwl), .dealer_win_light(dwl), .cards_used(cards_used),
    .reshuffle_req(reshuffle_req), .reshuffle_ack(ack),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties),
    .shoe_left(shoe_left), .busy(busy), .session_done(session_done),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Narrow-tally DUT for saturation
  logic       s_go, s_done, s_pwl, s_dwl, s_ack;
  logic [3:0] s_num;
  logic [2:0] s_cards;
  logic       s_start, s_req, s_busy, s_sdone, s_tmo;
  logic [1:0] s_pw, s_dw, s_ties;
  logic [5:0] s_shoe;
  logic [2:0] s_state;

  round_scheduler #(.COUNT_W(2)) dut_sat (
    .slow_clock(clk), .resetb(resetb), .go(s_go), .num_rounds(s_num),
    .round_start(s_start), .round_done(s_done),
    .player_win_light(s_pwl), .dealer_win_light(s_dwl), .cards_used(s_cards),
    .reshuffle_req(s_req), .reshuffle_ack(s_ack),
    .player_wins(s_pw), .dealer_wins(s_dw), .ties(s_ties),
    .shoe_left(s_shoe), .busy(s_busy), .session_done(s_sdone),
    .timeout_err(s_tmo), .dbg_state(s_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a round_start pulse, checks it lasts one cycle, then returns
  // round_done with the given result 5 cycles after the pulse.
  task automatic serve_round(input logic p, input logic d, input logic [2:0] cu);
    int n = 0;
    logic extra = 1'b0;
    while (!round_start && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (round_start !== 1'b1) begin
      errors++;
      $display("FAIL round_start_wait: round_start=%b after %0d cycles, required 1", round_start, n);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (round_start) extra = 1'b1;
    end
    round_done = 1'b1; pwl = p; dwl = d; cards_used = cu;
    tick();
    round_done = 1'b0; pwl = 1'b0; dwl = 1'b0; cards_used = 3'd0;
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL round_start_width: extra pulse=%b, required 0", extra);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!session_done && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (session_done !== 1'b1) begin
      errors++;
      $display("FAIL session_done_wait: session_done=%b, required 1", session_done);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b1;
    tick(); tick();
    resetb = 1'b0;
    tick();
    checks++;
    if ({round_start, reshuffle_req, busy, session_done, timeout_err, dbg_state} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {round_start, reshuffle_req, busy, session_done, timeout_err, dbg_state});
    end
    checks++;
    if ({player_wins, dealer_wins, ties, shoe_left} !== {24'd0, 6'd52}) begin
      errors++;
      $display("FAIL reset_tallies: pw=%0d dw=%0d t=%0d shoe=%0d, required 0/0/0/52",
               player_wins, dealer_wins, ties, shoe_left);
    end
  endtask

  task automatic test_three_rounds();
    ack = 1'b1;  // must be ignored: the shoe never reaches SHUFFLE here
    num_rounds = 4'd3;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if ({busy, round_start} !== 2'b10) begin
      errors++;
      $display("FAIL start_latency_t1: busy,round_start=%b, required 10", {busy, round_start});
    end
    tick();
    checks++;
    if (round_start !== 1'b1) begin
      errors++;
      $display("FAIL start_latency_t2: round_start=%b, required 1", round_start);
    end
    serve_round(1'b1, 1'b0, 3'd4);
    serve_round(1'b0, 1'b1, 3'd4);
    serve_round(1'b1, 1'b1, 3'd4);
    wait_done();
    ack = 1'b0;
    checks++;
    if ({player_wins, dealer_wins, ties, shoe_left, busy} !== {8'd1, 8'd1, 8'd1, 6'd40, 1'b0}) begin
      errors++;
      $display("FAIL three_rounds: pw=%0d dw=%0d t=%0d shoe=%0d busy=%b, required 1/1/1/40/0",
               player_wins, dealer_wins, ties, shoe_left, busy);
    end
    tick();
    checks++;
    if (session_done !== 1'b0) begin
      errors++;
      $display("FAIL done_to_idle: session_done=%b, required 0", session_done);
    end
  endtask

  task automatic test_zero_rounds();
    logic seen = 1'b0;
    num_rounds = 4'd0;
    go = 1'b1;
    tick();
    checks++;
    if ({session_done, busy, round_start} !== 3'b100) begin
      errors++;
      $display("FAIL zero_rounds_done: done,busy,start=%b, required 100",
               {session_done, busy, round_start});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy || round_start || !session_done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL zero_rounds_hold: left DONE while go high=%b, required 0", seen);
    end
    checks++;
    if ({player_wins, dealer_wins, ties, shoe_left} !== {24'd0, 6'd40}) begin
      errors++;
      $display("FAIL zero_rounds_tallies: pw=%0d dw=%0d t=%0d shoe=%0d, required 0/0/0/40",
               player_wins, dealer_wins, ties, shoe_left);
    end
    go = 1'b0;
    tick();
    checks++;
    if (session_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_rounds_idle: session_done=%b, required 0", session_done);
    end
  endtask

  task automatic test_reshuffle();
    int  n = 0;
    logic bad = 1'b0;
    test_reset();
    num_rounds = 4'd9;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int r = 0; r < 8; r++) serve_round(1'b1, 1'b0, 3'd6);
    while (!reshuffle_req && n < 40) begin
      if (round_start) bad = 1'b1;
      tick();
      n++;
    end
    checks++;
    if ({reshuffle_req, shoe_left, bad} !== {1'b1, 6'd4, 1'b0}) begin
      errors++;
      $display("FAIL reshuffle_req: req=%b shoe=%0d early_start=%b, required 1/4/0",
               reshuffle_req, shoe_left, bad);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (round_start || !reshuffle_req) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reshuffle_wait: start or req drop while ack low=%b, required 0", bad);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({round_start, reshuffle_req, shoe_left} !== {2'b10, 6'd52}) begin
      errors++;
      $display("FAIL reshuffle_ack: start=%b req=%b shoe=%0d, required 1/0/52",
               round_start, reshuffle_req, shoe_left);
    end
    serve_round(1'b1, 1'b0, 3'd6);
    wait_done();
    checks++;
    if ({player_wins, shoe_left} !== {8'd9, 6'd46}) begin
      errors++;
      $display("FAIL reshuffle_final: pw=%0d shoe=%0d, required 9/46", player_wins, shoe_left);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    num_rounds = 4'd2;
    go = 1'b1;
    tick();
    go = 1'b0;
    while (!round_start && n < 20) begin
      tick();
      n++;
    end
    tick();  // now in WAIT
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
    tick();
    round_done = 1'b1; pwl = 1'b1; dwl = 1'b0; cards_used = 3'd5;
    tick();
    round_done = 1'b0; pwl = 1'b0; cards_used = 3'd0;
    tick();
    checks++;
    if ({round_start, reshuffle_req, busy, session_done, timeout_err, dbg_state} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_wait_flags: got %b, required 00000000",
               {round_start, reshuffle_req, busy, session_done, timeout_err, dbg_state});
    end
    checks++;
    if ({player_wins, dealer_wins, ties, shoe_left} !== {24'd0, 6'd52}) begin
      errors++;
      $display("FAIL reset_mid_wait_tallies: pw=%0d dw=%0d t=%0d shoe=%0d, required 0/0/0/52",
               player_wins, dealer_wins, ties, shoe_left);
    end
  endtask

  task automatic test_saturate();
    int n;
    s_num = 4'd5;
    s_go = 1'b1;
    tick();
    s_go = 1'b0;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (!s_start && n < 60) begin
        tick();
        n++;
      end
      tick(); tick();
      s_done = 1'b1; s_pwl = 1'b1; s_dwl = 1'b0; s_cards = 3'd4;
      tick();
      s_done = 1'b0; s_pwl = 1'b0; s_cards = 3'd0;
    end
    n = 0;
    while (!s_sdone && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if ({s_sdone, s_pw, s_dw, s_ties, s_shoe} !== {1'b1, 2'd3, 2'd0, 2'd0, 6'd32}) begin
      errors++;
      $display("FAIL saturate: done=%b pw=%0d dw=%0d t=%0d shoe=%0d, required 1/3/0/0/32",
               s_sdone, s_pw, s_dw, s_ties, s_shoe);
    end
  endtask

`ifdef ROUND_WATCHDOG_EN
  task automatic test_watchdog();
    num_rounds = 4'd1;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_done();
    checks++;
    if ({timeout_err, player_wins, dealer_wins, ties} !== {1'b1, 24'd0}) begin
      errors++;
      $display("FAIL watchdog: tmo=%b pw=%0d dw=%0d t=%0d, required 1/0/0/0",
               timeout_err, player_wins, dealer_wins, ties);
    end
    tick();
    num_rounds = 4'd0;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_clear: tmo=%b, required 0", timeout_err);
    end
    tick();
  endtask
`endif

  initial begin
    resetb = 1'b1;
    go = 1'b0; num_rounds = 4'd0; round_done = 1'b0; pwl = 1'b0; dwl = 1'b0;
    cards_used = 3'd0; ack = 1'b0;
    s_go = 1'b0; s_num = 4'd0; s_done = 1'b0; s_pwl = 1'b0; s_dwl = 1'b0;
    s_cards = 3'd0; s_ack = 1'b0;
    test_reset();
    test_three_rounds();
    test_zero_rounds();
    test_reshuffle();
    test_reset_mid_wait();
    test_saturate();
`ifdef ROUND_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
